// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO: address-width calculation and
// parameter legality checks used at elaboration time.
package fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int data_width,
                                        input int fifo_depth,
                                        input int afull_thresh,
                                        input int aempty_thresh);
        return (data_width >= 1) &&
               (fifo_depth >= 2) && is_pow2(fifo_depth) &&
               (afull_thresh >= 1) && (afull_thresh <= fifo_depth) &&
               (aempty_thresh >= 0) && (aempty_thresh <= fifo_depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for sync_fifo: one write port, one registered read
// port. Neither the array nor the read register is reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and almost-full/empty flags.
// Define FIFO_ERR_EN to add sticky overflow/underflow flags and err_clr.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       wr_en,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       almost_empty,
`ifdef FIFO_ERR_EN
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clr,
`endif
    output logic [clog2(FIFO_DEPTH):0] count
);

    localparam int ADDR_WIDTH = clog2(FIFO_DEPTH);
    localparam int PTR_W      = ADDR_WIDTH + 1;

    localparam logic [PTR_W-1:0] DEPTH_C  = PTR_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_THRESH);
    localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_THRESH);

    if (!params_legal(DATA_WIDTH, FIFO_DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
        $error("sync_fifo: illegal parameter combination");
    end

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      count_q, count_d;
    logic                  full_q, empty_q, afull_q, aempty_q;
    logic                  rd_valid_q;
    logic                  rd_seen_q;
    logic                  wr_accept, rd_accept;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // Acceptance uses the registered flags only, so a full FIFO never takes a
    // write and an empty FIFO never falls a write through to the read side.
    always_comb begin
        wr_accept = wr_en && !full_q;
        rd_accept = rd_en && !empty_q;
        wr_ptr_d  = wr_ptr_q + PTR_W'(wr_accept);
        rd_ptr_d  = rd_ptr_q + PTR_W'(rd_accept);
        count_d   = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_seen_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == DEPTH_C);
            empty_q    <= (count_d == '0);
            afull_q    <= (count_d >= AFULL_C);
            aempty_q   <= (count_d <= AEMPTY_C);
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_seen_q <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_accept),
        .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (mem_rd_data)
    );

    // The RAM read register has no reset; mask it until the first read after reset.
    assign rd_data      = rd_seen_q ? mem_rd_data : '0;
    assign rd_valid     = rd_valid_q;
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;

`ifdef FIFO_ERR_EN
    logic overflow_q, underflow_q;

    // A new error in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && full_q) begin
                overflow_q <= 1'b1;
            end else if (err_clr) begin
                overflow_q <= 1'b0;
            end
            if (rd_en && empty_q) begin
                underflow_q <= 1'b1;
            end else if (err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo (8 x 8, afull 6, aempty 2); error-flag
// checks are included when FIFO_ERR_EN is defined.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          full, almost_full, rd_valid, empty, almost_empty;
    logic [DW-1:0] rd_data;
    logic [3:0]    count;
`ifdef FIFO_ERR_EN
    logic          overflow, underflow;
    logic          err_clr = 1'b0;
`endif

    sync_fifo #(
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .AFULL_THRESH  (AF),
        .AEMPTY_THRESH (AE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .full         (full),
        .almost_full  (almost_full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .almost_empty (almost_empty),
`ifdef FIFO_ERR_EN
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr),
`endif
        .count        (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_q   [$];
    logic          rv_exp = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
    task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re);
        bit aw, ar;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        ar = re && (model_q.size() > 0);
        aw = we && (model_q.size() < DEPTH);
        if (ar) exp_q.push_back(model_q.pop_front());
        if (aw) model_q.push_back(wd);
        @(posedge clk);
        #1;
        rv_exp = ar;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
    endtask

    task automatic check_flags();
        int m;
        m = model_q.size();
        chk("count",        int'(count),        m);
        chk("empty",        int'(empty),        int'(m == 0));
        chk("full",         int'(full),         int'(m == DEPTH));
        chk("almost_full",  int'(almost_full),  int'(m >= AF));
        chk("almost_empty", int'(almost_empty), int'(m <= AE));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_count"},        int'(count),        0);
        chk({tag, "_empty"},        int'(empty),        1);
        chk({tag, "_full"},         int'(full),         0);
        chk({tag, "_almost_empty"}, int'(almost_empty), 1);
        chk({tag, "_almost_full"},  int'(almost_full),  0);
        chk({tag, "_rd_valid"},     int'(rd_valid),     0);
        chk({tag, "_rd_data"},      int'(rd_data),      0);
    endtask

    // Monitor: compares every presented read word against the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("rd_valid", int'(rd_valid), int'(rv_exp));
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rd_data: got 0x%0h, expected no word", rd_data);
                end else begin
                    chk("rd_data", int'(rd_data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;

        // Fill to full, then one rejected write
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, DW'(i), 1'b0);
            check_flags();
        end
        chk("full_at_8", int'(full), 1);
        chk("afull_at_8", int'(almost_full), 1);
        cycle(1'b1, 8'h99, 1'b0);
        chk("count_after_9th", int'(count), 8);
        check_flags();

        // Drain
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, 1'b1);
            check_flags();
        end
        chk("empty_after_drain", int'(empty), 1);
        cycle(1'b0, '0, 1'b0);
        chk("rd_data_hold", int'(rd_data), 8'h08);

        // Simultaneous read/write at count 4 across pointer wrap
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h10 + DW'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'h20 + DW'(i), 1'b1);
            chk("count_simul", int'(count), 4);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
        check_flags();

        // Boundaries: full with both requests, empty with both requests
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h30 + DW'(i), 1'b0);
        cycle(1'b1, 8'hAA, 1'b1);
        chk("count_full_both", int'(count), 7);
        check_flags();
        for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1);
        check_flags();
        cycle(1'b1, 8'hBB, 1'b1);
        chk("count_empty_both", int'(count), 1);
        check_flags();
        cycle(1'b0, '0, 1'b1);

        // Reset mid-stream with a read in flight
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h40 + DW'(i), 1'b0);
        cycle(1'b0, '0, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        model_q.delete();
        exp_q.delete();
        rv_exp = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        cycle(1'b1, 8'h5A, 1'b0);
        check_flags();
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

`ifdef FIFO_ERR_EN
        chk("overflow_init",  int'(overflow),  0);
        chk("underflow_init", int'(underflow), 0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h60 + DW'(i), 1'b0);
        cycle(1'b1, 8'hEE, 1'b0);
        chk("overflow_set", int'(overflow), 1);
        cycle(1'b0, '0, 1'b0);
        chk("overflow_sticky", int'(overflow), 1);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
        chk("underflow_pre", int'(underflow), 0);
        cycle(1'b0, '0, 1'b1);
        chk("underflow_set", int'(underflow), 1);
        err_clr = 1'b1;
        cycle(1'b0, '0, 1'b1);
        chk("overflow_clr", int'(overflow), 0);
        chk("underflow_set_beats_clr", int'(underflow), 1);
        cycle(1'b0, '0, 1'b0);
        chk("underflow_clr", int'(underflow), 0);
        err_clr = 1'b0;
`endif

        repeat (2) cycle(1'b0, '0, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
